// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative MULTU/DIVU sequencer.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_MULTU = 1'b0;
  localparam logic OP_DIVU  = 1'b1;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CNT_W = 6;

endpackage

// File: rtl/muldiv_seq_if.sv
// EX-stage <-> mul/div sequencer signal bundle. The core drives through
// master, the sequencer sits on slave.
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_div;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             hilo_rd;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             stall;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, is_div, src_a, src_b, flush, hilo_rd, wr_hi, wr_lo, wdata,
    input  busy, stall, done, div_zero, hi, lo
  );

  modport slave (
    input  start, is_div, src_a, src_b, flush, hilo_rd, wr_hi, wr_lo, wdata,
    output busy, stall, done, div_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration, purely combinational.
//   MULTU: {carry,acc,mplier} = ({acc,mplier} + (mplier[0] ? mcand<<W : 0)) >> 1
//   DIVU : restoring step, {rem,quot} shifted left, then trial subtract.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] acc_i,    // accumulator (mul) / remainder (div)
  input  logic [WIDTH-1:0] mq_i,     // multiplier (mul) / quotient-dividend (div)
  input  logic [WIDTH-1:0] opnd_i,   // multiplicand (mul) / divisor (div)
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] mq_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] quot_sh;
  logic             fits;

  // Datapath for both step kinds; the op selects which result is used.
  always_comb begin
    sum     = {1'b0, acc_i} + (mq_i[0] ? {1'b0, opnd_i} : '0);
    rem_sh  = {acc_i, mq_i[WIDTH-1]};
    quot_sh = {mq_i[WIDTH-2:0], 1'b0};
    // A failed trial means rem_sh < divisor < 2**WIDTH, so dropping rem_sh's
    // top bit below is safe; a successful trial leaves a remainder < divisor.
    fits    = (rem_sh >= {1'b0, opnd_i});
    if (is_div_i == OP_DIVU) begin
      acc_o = fits ? (rem_sh[WIDTH-1:0] - opnd_i) : rem_sh[WIDTH-1:0];
      mq_o  = {quot_sh[WIDTH-1:1], fits};
    end else begin
      acc_o = sum[WIDTH:1];
      mq_o  = {sum[0], mq_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative unsigned MULTU/DIVU sequencer with HI/LO, pipeline stall and squash.
//   state | meaning
//   IDLE  | no op in flight; MTHI/MTLO apply, new op may be accepted
//   RUN   | one radix-2 step per cycle, counter counts down to 1
//   DONE  | done pulse; HI/LO commit at the closing edge unless flushed
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input logic         clk,
  input logic         rst_n,
  muldiv_seq_if.slave bus
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] step_acc;
  logic [WIDTH-1:0] step_mq;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (op_q),
    .acc_i    (acc_q),
    .mq_i     (mq_q),
    .opnd_i   (opnd_q),
    .acc_o    (step_acc),
    .mq_o     (step_mq)
  );

  // Next-state and datapath update for the whole sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE: begin
        if (bus.wr_hi) hi_d = bus.wdata;
        if (bus.wr_lo) lo_d = bus.wdata;
        if (bus.start && !bus.flush) begin
          op_d  = bus.is_div;
          cnt_d = CNT_W'(WIDTH);
          dz_d  = 1'b0;
          if (bus.is_div == OP_DIVU && bus.src_b == '0) begin
            // Preload the div-by-zero result so DONE commits acc/mq uniformly.
            acc_d   = bus.src_a;
            mq_d    = '1;
            opnd_d  = bus.src_b;
            dz_d    = 1'b1;
            state_d = DONE;
          end else begin
            acc_d   = '0;
            mq_d    = (bus.is_div == OP_DIVU) ? bus.src_a : bus.src_b;
            opnd_d  = (bus.is_div == OP_DIVU) ? bus.src_b : bus.src_a;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          acc_d = step_acc;
          mq_d  = step_mq;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!bus.flush) begin
          hi_d = acc_q;
          lo_d = mq_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MULTU;
      acc_q   <= '0;
      mq_q    <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
    end
  end

  // Status outputs; stall and done react to this cycle's requests/flush.
  assign bus.busy     = (state_q != IDLE);
  assign bus.stall    = bus.busy & (bus.start | bus.hilo_rd | bus.wr_hi | bus.wr_lo);
  assign bus.done     = (state_q == DONE) & ~bus.flush;
  assign bus.div_zero = dz_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized and directed checks of muldiv_seq against a plain arithmetic model.
module tb_muldiv_seq;

  localparam int W = 32;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  muldiv_seq_if #(.WIDTH(W)) bus ();

  muldiv_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the architectural result of one op.
  task automatic model(input logic d, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] ehi, output logic [W-1:0] elo,
                       output logic edz, output int elat);
    logic [2*W-1:0] p;
    if (!d) begin
      p = 64'(a) * 64'(b);
      ehi = p[2*W-1:W]; elo = p[W-1:0]; edz = 1'b0; elat = W;
    end else if (b == 0) begin
      ehi = a; elo = '1; edz = 1'b1; elat = 0;
    end else begin
      ehi = a % b; elo = a / b; edz = 1'b0; elat = W;
    end
  endtask

  // Present an op from a negedge; returns just after the accepting edge.
  task automatic issue(input logic d, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1; bus.is_div = d; bus.src_a = a; bus.src_b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Cycles after acceptance until done is seen; -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin lat = i; break; end
    end
  endtask

  task automatic idle_inputs();
    bus.start = 0; bus.is_div = 0; bus.src_a = '0; bus.src_b = '0; bus.flush = 0;
    bus.hilo_rd = 0; bus.wr_hi = 0; bus.wr_lo = 0; bus.wdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.div_zero !== 1'b0) begin failures++; $display("FAIL reset_dz got=%b exp=0", bus.div_zero); end
    checks++; if (bus.hi !== '0 || bus.lo !== '0) begin failures++; $display("FAIL reset_hilo got=%h_%h exp=0_0", bus.hi, bus.lo); end
    bus.start = 1'b1;
    #1;
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", bus.stall); end
    bus.start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Run one op to completion and compare against the model.
  task automatic test_one(input string tag, input logic d, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] ehi, elo; logic edz; int elat, lat;
    model(d, a, b, ehi, elo, edz, elat);
    issue(d, a, b);
    wait_done(lat);
    checks++; if (lat != elat) begin failures++; $display("FAIL %s_latency got=%0d exp=%0d", tag, lat, elat); end
    @(negedge clk);
    checks++; if (bus.hi !== ehi || bus.lo !== elo) begin failures++;
      $display("FAIL %s_hilo a=%h b=%h div=%b got=%h_%h exp=%h_%h", tag, a, b, d, bus.hi, bus.lo, ehi, elo); end
    checks++; if (bus.div_zero !== edz) begin failures++; $display("FAIL %s_dz got=%b exp=%b", tag, bus.div_zero, edz); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL %s_idle busy=%b exp=0", tag, bus.busy); end
  endtask

  task automatic test_directed();
    test_one("mul_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    test_one("div_100_7", 1'b1, 32'd100, 32'd7);
    test_one("div_zero", 1'b1, 32'd5, 32'd0);
    test_one("div_big", 1'b1, 32'hFFFF_FFFF, 32'h8000_0001);
    test_one("mul_zero", 1'b0, 32'h1234_5678, 32'd0);
  endtask

  task automatic test_random();
    logic d; logic [W-1:0] a, b;
    for (int n = 0; n < 24; n++) begin
      d = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = '0;
        1: b = W'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      test_one("rand", d, a, b);
    end
  endtask

  task automatic test_stall();
    issue(1'b0, 32'd3, 32'd4);
    bus.hilo_rd = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++; if (bus.stall !== (i <= W)) begin failures++;
        $display("FAIL stall_hold cycle=%0d got=%b exp=%b", i, bus.stall, (i <= W)); end
    end
    checks++; if (bus.lo !== 32'd12) begin failures++; $display("FAIL stall_mflo got=%h exp=%h", bus.lo, 32'd12); end
    bus.hilo_rd = 1'b0;
  endtask

  task automatic test_flush();
    int seen;
    bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wdata = 32'hA5;
    @(posedge clk); #1;
    bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
    @(negedge clk);
    checks++; if (bus.hi !== 32'hA5 || bus.lo !== 32'hA5) begin failures++;
      $display("FAIL mthi_mtlo got=%h_%h exp=a5_a5", bus.hi, bus.lo); end
    issue(1'b1, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL flush_idle busy=%b exp=0", bus.busy); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL flush_nodone got=%0d exp=0", seen); end
    checks++; if (bus.hi !== 32'hA5 || bus.lo !== 32'hA5) begin failures++;
      $display("FAIL flush_hilo got=%h_%h exp=a5_a5", bus.hi, bus.lo); end
    // Squash while in DONE also suppresses the commit and the pulse.
    issue(1'b1, 32'd9, 32'd0);
    bus.flush = 1'b1;
    #1;
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL flush_done_pulse got=%b exp=0", bus.done); end
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    checks++; if (bus.hi !== 32'hA5 || bus.lo !== 32'hA5 || bus.busy !== 1'b0) begin failures++;
      $display("FAIL flush_in_done got=%h_%h busy=%b exp=a5_a5 busy=0", bus.hi, bus.lo, bus.busy); end
  endtask

  task automatic test_reset_midop();
    logic [W-1:0] ehi, elo; logic edz; int elat, lat;
    issue(1'b0, 32'h0001_0000, 32'h0003_0000);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_zero !== 1'b0 || bus.hi !== '0 || bus.lo !== '0) begin
      failures++; $display("FAIL midop_reset got busy=%b done=%b dz=%b hi=%h lo=%h exp=all0",
                           bus.busy, bus.done, bus.div_zero, bus.hi, bus.lo); end
    model(1'b0, 32'd123456, 32'd654321, ehi, elo, edz, elat);
    bus.wr_lo = 1'b1; bus.wdata = 32'd7;
    issue(1'b0, 32'd123456, 32'd654321);
    bus.wr_lo = 1'b0;
    @(negedge clk);
    checks++; if (bus.lo !== 32'd7 || bus.busy !== 1'b1) begin failures++;
      $display("FAIL start_mtlo got lo=%h busy=%b exp lo=7 busy=1", bus.lo, bus.busy); end
    wait_done(lat);
    checks++; if (lat != elat - 1) begin failures++; $display("FAIL start_mtlo_lat got=%0d exp=%0d", lat, elat - 1); end
    @(negedge clk);
    checks++; if (bus.hi !== ehi || bus.lo !== elo) begin failures++;
      $display("FAIL start_mtlo_result got=%h_%h exp=%h_%h", bus.hi, bus.lo, ehi, elo); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] h1, l1, h2, l2; logic z1, z2; int e1, e2, lat;
    model(1'b1, 32'd77777, 32'd13, h1, l1, z1, e1);
    model(1'b0, 32'hDEAD_BEEF, 32'h0000_1001, h2, l2, z2, e2);
    issue(1'b1, 32'd77777, 32'd13);
    wait_done(lat);
    bus.start = 1'b1; bus.is_div = 1'b0; bus.src_a = 32'hDEAD_BEEF; bus.src_b = 32'h0000_1001;
    #1;
    checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL b2b_stall got=%b exp=1", bus.stall); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.stall !== 1'b0) begin failures++;
      $display("FAIL b2b_bubble busy=%b stall=%b exp=0_0", bus.busy, bus.stall); end
    checks++; if (bus.hi !== h1 || bus.lo !== l1) begin failures++;
      $display("FAIL b2b_first got=%h_%h exp=%h_%h", bus.hi, bus.lo, h1, l1); end
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(lat);
    checks++; if (lat != e2) begin failures++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, e2); end
    @(negedge clk);
    checks++; if (bus.hi !== h2 || bus.lo !== l2) begin failures++;
      $display("FAIL b2b_second got=%h_%h exp=%h_%h", bus.hi, bus.lo, h2, l2); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_stall();
    test_flush();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
